frag_writer: RTL and testbench

//  Fragment back-end on the far side of the rasterizer's pixel output: accepts one fragment per

---
 rtl/frag_writer_if.sv | 30 +++
 rtl/frag_writer.sv | 141 ++++++++++++++
 tb/tb_frag_writer.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/frag_writer_if.sv
// Fragment writer bus bundle: pixel handshake, Z buffer port and framebuffer write port.
// Signal suffixes are from the point of view of the fragment writer.
interface frag_writer_if;
  logic         valid_pix_i;
  logic         ready_pix_o;
  logic [298:0] pix_data_i;
  logic         zb_rd_en_o;
  logic [16:0]  zb_addr_o;
  logic [15:0]  zb_rd_data_i;
  logic         zb_wr_en_o;
  logic [15:0]  zb_wr_data_o;
  logic         fb_wr_valid_o;
  logic         fb_wr_ready_i;
  logic [16:0]  fb_addr_o;
  logic [23:0]  fb_data_o;

  // Fragment writer side.
  modport slave (
    input  valid_pix_i, pix_data_i, zb_rd_data_i, fb_wr_ready_i,
    output ready_pix_o, zb_rd_en_o, zb_addr_o, zb_wr_en_o, zb_wr_data_o,
           fb_wr_valid_o, fb_addr_o, fb_data_o
  );

  // Rasterizer / memory side.
  modport master (
    output valid_pix_i, pix_data_i, zb_rd_data_i, fb_wr_ready_i,
    input  ready_pix_o, zb_rd_en_o, zb_addr_o, zb_wr_en_o, zb_wr_data_o,
           fb_wr_valid_o, fb_addr_o, fb_data_o
  );
endinterface

// File: rtl/frag_writer.sv
// Fragment back-end: barycentric interpolation of RGB888 and 16-bit Z, optional depth test,
// then framebuffer and Z buffer write for a linear-addressed screen.
module frag_writer #(
  parameter int unsigned SCR_W     = 320,
  parameter int unsigned SCR_H     = 240,
  parameter int unsigned FRAC      = 20,
  parameter bit          Z_TEST_EN = 1'b1
) (
  input  logic               clk_i,
  input  logic               reset_i,
  frag_writer_if.slave       bus_io,
  output logic [31:0]        frag_cnt_o,
  output logic [31:0]        pass_cnt_o
);

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StMul  = 3'd1;
  localparam logic [2:0] StZrd  = 3'd2;
  localparam logic [2:0] StZcmp = 3'd3;
  localparam logic [2:0] StWr   = 3'd4;

  logic [2:0]  r_state, w_state_next;
  logic [8:0]  r_x;
  logic [7:0]  r_y;
  logic [39:0] r_a0, r_a1, r_a2;  // {R,G,B,Z} per vertex
  logic [20:0] r_u, r_v;
  logic [23:0] r_rgb;
  logic [15:0] r_z;
  logic [16:0] r_addr;
  logic [31:0] r_frag_cnt, r_pass_cnt;

  logic [21:0] w_w0_raw;
  logic [20:0] w_w0;
  logic        w_in_range;
  logic [16:0] w_addr;
  logic        w_capture;
  logic        w_wr_fire;
  logic        w_unused_pix;

  // Low 40 bits of each vertex carry nothing this block uses.
  assign w_unused_pix = ^{bus_io.pix_data_i[241:202], bus_io.pix_data_i[161:122],
                          bus_io.pix_data_i[81:42]};

  function automatic logic [39:0] interp(input logic [15:0] a0, input logic [15:0] a1,
                                         input logic [15:0] a2, input logic [20:0] w0,
                                         input logic [20:0] w1, input logic [20:0] w2);
    logic [39:0] s;
    s = 40'(a0) * 40'(w0) + 40'(a1) * 40'(w1) + 40'(a2) * 40'(w2);
    return s >> FRAC;
  endfunction

  function automatic logic [7:0] sat8(input logic [39:0] a);
    return (|a[39:8]) ? 8'hFF : a[7:0];
  endfunction

  function automatic logic [15:0] sat16(input logic [39:0] a);
    return (|a[39:16]) ? 16'hFFFF : a[15:0];
  endfunction

  // w0 = 1.0 - u - v at 22 bits; a set sign bit means negative, clamp to zero.
  assign w_w0_raw   = 22'(1 << FRAC) - {1'b0, r_u} - {1'b0, r_v};
  assign w_w0       = w_w0_raw[21] ? '0 : w_w0_raw[20:0];
  assign w_in_range = (32'(r_x) < SCR_W) && (32'(r_y) < SCR_H);
  assign w_addr     = 17'(r_y) * 17'(SCR_W) + 17'(r_x);
  assign w_capture  = (r_state == StIdle) && bus_io.valid_pix_i;
  assign w_wr_fire  = (r_state == StWr) && bus_io.fb_wr_ready_i;

  // Next-state decode for the per-fragment pipeline.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle: if (bus_io.valid_pix_i) w_state_next = StMul;
      StMul: begin
        if (!w_in_range)    w_state_next = StIdle;
        else if (Z_TEST_EN) w_state_next = StZrd;
        else                w_state_next = StWr;
      end
      StZrd:  w_state_next = StZcmp;
      StZcmp: w_state_next = (r_z < bus_io.zb_rd_data_i) ? StWr : StIdle;
      StWr:   if (bus_io.fb_wr_ready_i) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // State, captured fragment, interpolated results and counters.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state    <= StIdle;
      r_x        <= '0;
      r_y        <= '0;
      r_a0       <= '0;
      r_a1       <= '0;
      r_a2       <= '0;
      r_u        <= '0;
      r_v        <= '0;
      r_rgb      <= '0;
      r_z        <= '0;
      r_addr     <= '0;
      r_frag_cnt <= '0;
      r_pass_cnt <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_capture) begin
        r_x        <= bus_io.pix_data_i[298:290];
        r_y        <= bus_io.pix_data_i[289:282];
        r_a2       <= bus_io.pix_data_i[281:242];
        r_a1       <= bus_io.pix_data_i[201:162];
        r_a0       <= bus_io.pix_data_i[121:82];
        r_u        <= bus_io.pix_data_i[41:21];
        r_v        <= bus_io.pix_data_i[20:0];
        r_frag_cnt <= r_frag_cnt + 32'd1;
      end
      if (r_state == StMul) begin
        r_rgb[23:16] <= sat8(interp({8'h0, r_a0[39:32]}, {8'h0, r_a1[39:32]},
                                    {8'h0, r_a2[39:32]}, w_w0, r_u, r_v));
        r_rgb[15:8]  <= sat8(interp({8'h0, r_a0[31:24]}, {8'h0, r_a1[31:24]},
                                    {8'h0, r_a2[31:24]}, w_w0, r_u, r_v));
        r_rgb[7:0]   <= sat8(interp({8'h0, r_a0[23:16]}, {8'h0, r_a1[23:16]},
                                    {8'h0, r_a2[23:16]}, w_w0, r_u, r_v));
        r_z          <= sat16(interp(r_a0[15:0], r_a1[15:0], r_a2[15:0], w_w0, r_u, r_v));
        r_addr       <= w_addr;
      end
      if (w_wr_fire) r_pass_cnt <= r_pass_cnt + 32'd1;
    end
  end

  // Output strobes decode from state; address/data come straight from registers.
  always_comb begin
    bus_io.ready_pix_o   = (r_state == StIdle);
    bus_io.zb_rd_en_o    = Z_TEST_EN && (r_state == StZrd);
    bus_io.zb_addr_o     = Z_TEST_EN ? r_addr : '0;
    bus_io.zb_wr_en_o    = Z_TEST_EN && w_wr_fire;
    bus_io.zb_wr_data_o  = Z_TEST_EN ? r_z : '0;
    bus_io.fb_wr_valid_o = (r_state == StWr);
    bus_io.fb_addr_o     = r_addr;
    bus_io.fb_data_o     = r_rgb;
    frag_cnt_o           = r_frag_cnt;
    pass_cnt_o           = r_pass_cnt;
  end

endmodule

// File: tb/tb_frag_writer.sv
// Self-checking bench for frag_writer: Z buffer memory model plus a write scoreboard.
module tb_frag_writer;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] frag_cnt, pass_cnt;

  frag_writer_if u_if ();

  frag_writer u_dut (
    .clk_i     (clk),
    .reset_i   (reset),
    .bus_io    (u_if.slave),
    .frag_cnt_o(frag_cnt),
    .pass_cnt_o(pass_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [16:0] addr;
    logic [23:0] data;
    logic [15:0] z;
  } wr_t;

  wr_t         fb_q[$];
  logic [16:0] rd_q[$];
  logic [15:0] zmem[int];
  int          exp_frag = 0;
  int          exp_pass = 0;
  logic        rd_pend  = 1'b0;
  logic [16:0] rd_addr  = '0;

  function automatic logic [15:0] zget(input int a);
    return zmem.exists(a) ? zmem[a] : 16'hFFFF;
  endfunction

  // Unused low bits get a junk pattern so misuse shows up.
  function automatic logic [79:0] vtx(input logic [23:0] rgb, input logic [15:0] z);
    return {rgb, z, 40'hA5_5A5A_A5A5};
  endfunction

  function automatic logic [15:0] mix(input logic [15:0] a0, input logic [15:0] a1,
                                      input logic [15:0] a2, input int u, input int v,
                                      input longint maxv);
    longint w0, s;
    w0 = longint'(1 << 20) - longint'(u) - longint'(v);
    if (w0 < 0) w0 = 0;
    s = (longint'(a0) * w0 + longint'(a1) * longint'(u) + longint'(a2) * longint'(v)) >>> 20;
    if (s > maxv) s = maxv;
    return 16'(s);
  endfunction

  task automatic send(input int x, input int y, input logic [79:0] v0, input logic [79:0] v1,
                      input logic [79:0] v2, input int u, input int v);
    int          t;
    int          a;
    logic [23:0] rgb;
    logic [15:0] z;
    t = 0;
    while (!u_if.ready_pix_o && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!u_if.ready_pix_o) check("send_timeout", 0, 1);
    if (x < 320 && y < 240) begin
      a   = y * 320 + x;
      rgb = {8'(mix({8'h0, v0[79:72]}, {8'h0, v1[79:72]}, {8'h0, v2[79:72]}, u, v, 255)),
             8'(mix({8'h0, v0[71:64]}, {8'h0, v1[71:64]}, {8'h0, v2[71:64]}, u, v, 255)),
             8'(mix({8'h0, v0[63:56]}, {8'h0, v1[63:56]}, {8'h0, v2[63:56]}, u, v, 255))};
      z   = mix(v0[55:40], v1[55:40], v2[55:40], u, v, 65535);
      rd_q.push_back(17'(a));
      if (z < zget(a)) fb_q.push_back('{addr: 17'(a), data: rgb, z: z});
    end
    u_if.pix_data_i  = {9'(x), 8'(y), v2, v1, v0, 21'(u), 21'(v)};
    u_if.valid_pix_i = 1'b1;
    exp_frag++;
    @(negedge clk);
    u_if.valid_pix_i = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    @(negedge clk);
    while (!u_if.ready_pix_o && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!u_if.ready_pix_o) check("idle_timeout", 0, 1);
  endtask

  task automatic set_fb_ready(input logic val);
    @(posedge clk);
    #1 u_if.fb_wr_ready_i = val;
  endtask

  task automatic wait_fb_valid();
    int t;
    t = 0;
    while (!u_if.fb_wr_valid_o && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!u_if.fb_wr_valid_o) check("wr_timeout", 0, 1);
  endtask

  // Z buffer model and write scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    if (reset) begin
      rd_pend           = 1'b0;
      u_if.zb_rd_data_i = '0;
    end else begin
      u_if.zb_rd_data_i = rd_pend ? zget(int'(rd_addr)) : 16'h0;
      rd_pend = u_if.zb_rd_en_o;
      rd_addr = u_if.zb_addr_o;
      if (u_if.zb_rd_en_o) begin
        if (rd_q.size() == 0) check("zb_rd_stray", 1, 0);
        else check("zb_rd_addr", u_if.zb_addr_o, rd_q.pop_front());
      end
      if (u_if.fb_wr_valid_o && u_if.fb_wr_ready_i) begin
        if (fb_q.size() == 0) begin
          check("fb_wr_stray", 1, 0);
        end else begin
          wr_t e;
          e = fb_q.pop_front();
          check("fb_addr", u_if.fb_addr_o, e.addr);
          check("fb_data", u_if.fb_data_o, e.data);
          check("zb_wr_en", u_if.zb_wr_en_o, 1);
          check("zb_wr_data", u_if.zb_wr_data_o, e.z);
          exp_pass++;
        end
      end else if (u_if.zb_wr_en_o) begin
        check("zb_wr_stray", 1, 0);
      end
      if (u_if.zb_wr_en_o) zmem[int'(u_if.zb_addr_o)] = u_if.zb_wr_data_o;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          t;
    int          x, y, u, v;
    logic [16:0] a0;
    logic [23:0] d0;

    reset              = 1'b1;
    u_if.valid_pix_i   = 1'b0;
    u_if.pix_data_i    = '0;
    u_if.fb_wr_ready_i = 1'b1;
    u_if.zb_rd_data_i  = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", u_if.ready_pix_o, 1);
    check("rst_fb_valid", u_if.fb_wr_valid_o, 0);
    check("rst_zb_rd", u_if.zb_rd_en_o, 0);
    check("rst_fb_addr", u_if.fb_addr_o, 0);
    check("rst_frag_cnt", frag_cnt, 0);
    check("rst_pass_cnt", pass_cnt, 0);
    reset = 1'b0;
    @(negedge clk);

    // Single red vertex, passes Z, check fb_wr latency.
    zmem[645] = 16'd200;
    send(5, 2, vtx(24'hFF0000, 16'd100), vtx(24'h0, 16'd0), vtx(24'h0, 16'd0), 0, 0);
    t = 1;
    while (!u_if.fb_wr_valid_o && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("lat_fb_valid", t, 4);
    wait_idle();
    check("zbuf_645", zget(645), 16'd100);
    check("frag_cnt_t1", frag_cnt, 1);
    check("pass_cnt_t1", pass_cnt, 1);

    // Half/half weights, clamped w0, colour saturation.
    send(10, 10, vtx(24'h0, 16'd0), vtx(24'h00FF00, 16'd0), vtx(24'h0000FF, 16'd0),
         'h80000, 'h80000);
    send(11, 10, vtx(24'hFFFFFF, 16'hFFFF), vtx(24'h102030, 16'd50), vtx(24'h010203, 16'd60),
         'h100000, 'h100000);
    send(12, 10, vtx(24'h0, 16'd0), vtx(24'hFF8000, 16'd10), vtx(24'hFF8000, 16'd10),
         'h100000, 'h100000);
    wait_idle();
    check("zbuf_w0_clamp", zget(10 * 320 + 11), 16'd110);

    // Random fragments with random Z buffer contents.
    for (int i = 0; i < 8; i++) begin
      x = int'($urandom_range(0, 319));
      y = int'($urandom_range(0, 239));
      u = int'($urandom_range(0, 32'h100000));
      v = int'($urandom_range(0, 32'h100000));
      zmem[y * 320 + x] = 16'($urandom);
      send(x, y, vtx(24'($urandom), 16'($urandom)), vtx(24'($urandom), 16'($urandom)),
           vtx(24'($urandom), 16'($urandom)), u, v);
    end
    wait_idle();
    check("frag_cnt_rand", frag_cnt, exp_frag);
    check("pass_cnt_rand", pass_cnt, exp_pass);

    // Equal Z fails the strict compare.
    zmem[20 * 320 + 20] = 16'd300;
    send(20, 20, vtx(24'h123456, 16'd300), vtx(24'h0, 16'd0), vtx(24'h0, 16'd0), 0, 0);
    t = 1;
    while (!u_if.ready_pix_o && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("lat_zfail_ready", t, 4);
    check("frag_cnt_zfail", frag_cnt, exp_frag);
    check("pass_cnt_zfail", pass_cnt, exp_pass);

    // Out-of-range coordinates are dropped after MUL.
    send(320, 0, vtx(24'hFFFFFF, 16'd1), vtx(24'h0, 16'd0), vtx(24'h0, 16'd0), 0, 0);
    t = 1;
    while (!u_if.ready_pix_o && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("lat_drop_ready", t, 2);
    send(0, 240, vtx(24'hFFFFFF, 16'd1), vtx(24'h0, 16'd0), vtx(24'h0, 16'd0), 0, 0);
    wait_idle();
    check("frag_cnt_oob", frag_cnt, exp_frag);
    check("pass_cnt_oob", pass_cnt, exp_pass);

    // Framebuffer back-pressure: outputs hold for 10 cycles, then one write.
    set_fb_ready(1'b0);
    @(negedge clk);
    send(30, 30, vtx(24'hABCDEF, 16'd7), vtx(24'h0, 16'd0), vtx(24'h0, 16'd0), 0, 0);
    wait_fb_valid();
    a0 = u_if.fb_addr_o;
    d0 = u_if.fb_data_o;
    check("stall_addr0", a0, 17'(30 * 320 + 30));
    check("stall_data0", d0, 24'hABCDEF);
    repeat (10) begin
      @(negedge clk);
      check("stall_valid", u_if.fb_wr_valid_o, 1);
      check("stall_addr", u_if.fb_addr_o, a0);
      check("stall_data", u_if.fb_data_o, d0);
      check("stall_ready_pix", u_if.ready_pix_o, 0);
    end
    set_fb_ready(1'b1);
    wait_idle();
    check("pass_cnt_stall", pass_cnt, exp_pass);
    check("zbuf_stall", zget(30 * 320 + 30), 16'd7);

    // Reset while stalled in WR.
    zmem[40 * 320 + 40] = 16'd1000;
    set_fb_ready(1'b0);
    @(negedge clk);
    send(40, 40, vtx(24'h445566, 16'd9), vtx(24'h0, 16'd0), vtx(24'h0, 16'd0), 0, 0);
    wait_fb_valid();
    reset = 1'b1;
    @(negedge clk);
    check("wrst_ready", u_if.ready_pix_o, 1);
    check("wrst_fb_valid", u_if.fb_wr_valid_o, 0);
    check("wrst_zb_wr", u_if.zb_wr_en_o, 0);
    check("wrst_zb_rd", u_if.zb_rd_en_o, 0);
    check("wrst_fb_addr", u_if.fb_addr_o, 0);
    check("wrst_fb_data", u_if.fb_data_o, 0);
    check("wrst_zb_addr", u_if.zb_addr_o, 0);
    check("wrst_zb_data", u_if.zb_wr_data_o, 0);
    check("wrst_frag_cnt", frag_cnt, 0);
    check("wrst_pass_cnt", pass_cnt, 0);
    reset = 1'b0;
    fb_q.delete();
    rd_q.delete();
    exp_frag = 0;
    exp_pass = 0;
    check("wrst_zbuf_kept", zget(40 * 320 + 40), 16'd1000);
    set_fb_ready(1'b1);
    @(negedge clk);
    send(40, 40, vtx(24'h445566, 16'd9), vtx(24'h0, 16'd0), vtx(24'h0, 16'd0), 0, 0);
    wait_idle();
    check("post_rst_frag_cnt", frag_cnt, 1);
    check("post_rst_pass_cnt", pass_cnt, 1);
    check("post_rst_zbuf", zget(40 * 320 + 40), 16'd9);

    repeat (3) @(negedge clk);
    check("fb_q_drained", fb_q.size(), 0);
    check("rd_q_drained", rd_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
